// File: rtl/unidade_pc.sv
// unidade_pc: program counter and fetch sequencing ahead of the decoder.
// Ports: clock/reset_n, decoder flow-control (Jump, Jal, Jr, Branch,
//   BranchNE, OpIn, OpHalt), Zero, EnderecoJump, Imediato, RegJr,
//   BotaoConfirma (raw button); outputs PC, PCmais1, LiberaIn,
//   AguardandoIn, Parado.
module unidade_pc #(
  parameter int LARGURA_PC       = 10,
  parameter int ENDERECO_INICIAL = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  Jump,
  input  logic                  Jal,
  input  logic                  Jr,
  input  logic                  Branch,
  input  logic                  BranchNE,
  input  logic                  OpIn,
  input  logic                  OpHalt,
  input  logic                  Zero,
  input  logic [25:0]           EnderecoJump,
  input  logic [15:0]           Imediato,
  input  logic [31:0]           RegJr,
  input  logic                  BotaoConfirma,
  output logic [LARGURA_PC-1:0] PC,
  output logic [LARGURA_PC-1:0] PCmais1,
  output logic                  LiberaIn,
  output logic                  AguardandoIn,
  output logic                  Parado
);

  localparam logic [LARGURA_PC-1:0] PC_INICIAL =
    ENDERECO_INICIAL[LARGURA_PC-1:0];
  localparam logic [LARGURA_PC-1:0] UM = 1;

  // 2'b11 is never entered; the default branch treats it as EXECUTA.
  typedef enum logic [1:0] {
    EXECUTA   = 2'b00,
    ESPERA_IN = 2'b01,
    PARADO    = 2'b10
  } estado_t;

  estado_t estado, estado_prox;

  logic [LARGURA_PC-1:0] pc, pc_prox;
  logic [LARGURA_PC-1:0] pc_mais1;
  logic [LARGURA_PC-1:0] pc_desvio;
  logic [31:0]           imed_ext;
  logic                  desvio_tomado;
  logic                  libera;

  logic sync1, sync2, anterior;
  logic borda;

  // Button: two synchronizer flops, a third flop for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      anterior <= 1'b0;
    end else begin
      sync1    <= BotaoConfirma;
      sync2    <= sync1;
      anterior <= sync2;
    end
  end

  assign borda = sync2 & ~anterior;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc     <= PC_INICIAL;
      estado <= EXECUTA;
    end else begin
      pc     <= pc_prox;
      estado <= estado_prox;
    end
  end

  // All PC arithmetic wraps modulo 2^LARGURA_PC by truncation.
  assign pc_mais1  = pc + UM;
  assign imed_ext  = {{16{Imediato[15]}}, Imediato};
  assign pc_desvio = pc_mais1 + imed_ext[LARGURA_PC-1:0];

  assign desvio_tomado = (Branch & Zero) | (BranchNE & ~Zero);

  always_comb begin
    pc_prox     = pc;
    estado_prox = estado;
    libera      = 1'b0;
    case (estado)
      ESPERA_IN: begin
        if (borda) begin
          libera      = 1'b1;
          pc_prox     = pc_mais1;
          estado_prox = EXECUTA;
        end
      end
      PARADO: begin
        pc_prox     = pc;
        estado_prox = PARADO;
      end
      default: begin
        // Priority order; a borda coinciding with OpIn is dropped.
        if (OpHalt) begin
          estado_prox = PARADO;
        end else if (OpIn) begin
          estado_prox = ESPERA_IN;
        end else if (Jr) begin
          pc_prox = RegJr[LARGURA_PC-1:0];
        end else if (Jump || Jal) begin
          pc_prox = EnderecoJump[LARGURA_PC-1:0];
        end else if (desvio_tomado) begin
          pc_prox = pc_desvio;
        end else begin
          pc_prox = pc_mais1;
        end
        estado_prox = (OpHalt) ? PARADO :
                      (OpIn)   ? ESPERA_IN : EXECUTA;
      end
    endcase
  end

  assign PC           = pc;
  assign PCmais1      = pc_mais1;
  assign LiberaIn     = libera;
  assign AguardandoIn = (estado == ESPERA_IN) && !borda;
  assign Parado       = (estado == PARADO);

  // Upper address bits beyond the PC width are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{RegJr, EnderecoJump, imed_ext};

endmodule

// File: tb/tb_unidade_pc.sv
// tb_unidade_pc: self-checking bench for unidade_pc.
// Directed scenarios plus randomized flow control against a PC model.
module tb_unidade_pc;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        Jump, Jal, Jr, Branch, BranchNE;
  logic        OpIn, OpHalt, Zero;
  logic [25:0] EnderecoJump;
  logic [15:0] Imediato;
  logic [31:0] RegJr;
  logic        BotaoConfirma;
  logic [9:0]  PC, PCmais1;
  logic        LiberaIn, AguardandoIn, Parado;

  int n_checks = 0;
  int n_fail   = 0;

  unidade_pc #(.LARGURA_PC(10), .ENDERECO_INICIAL(0)) dut (
    .clock(clock), .reset_n(reset_n),
    .Jump(Jump), .Jal(Jal), .Jr(Jr),
    .Branch(Branch), .BranchNE(BranchNE),
    .OpIn(OpIn), .OpHalt(OpHalt), .Zero(Zero),
    .EnderecoJump(EnderecoJump), .Imediato(Imediato),
    .RegJr(RegJr), .BotaoConfirma(BotaoConfirma),
    .PC(PC), .PCmais1(PCmais1), .LiberaIn(LiberaIn),
    .AguardandoIn(AguardandoIn), .Parado(Parado)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic clear_ctl;
    Jump = 0; Jal = 0; Jr = 0; Branch = 0; BranchNE = 0;
    OpIn = 0; OpHalt = 0; Zero = 0;
    EnderecoJump = 0; Imediato = 0; RegJr = 0;
  endtask

  task automatic goto_pc(input int t);
    clear_ctl();
    Jump = 1;
    EnderecoJump = 26'(t);
    tick();
    clear_ctl();
  endtask

  task automatic test_reset;
    reset_n = 0;
    BotaoConfirma = 0;
    clear_ctl();
    #3;
    n_checks++;
    if ({PC, LiberaIn, AguardandoIn, Parado} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_state got pc=%0d lib=%b wait=%b halt=%b want 0",
               PC, LiberaIn, AguardandoIn, Parado);
    end
    tick();
    reset_n = 1;
    #1;
    n_checks++;
    if (PC !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_release got pc=%0d want 0", PC);
    end
  endtask

  task automatic test_sequential;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if (PC !== 10'(i)) begin
        n_fail++;
        $display("FAIL seq_pc got %0d want %0d", PC, i);
      end
    end
    #3;
    reset_n = 0;
    #1;
    n_checks++;
    if (PC !== 10'd0) begin
      n_fail++;
      $display("FAIL async_reset got %0d want 0", PC);
    end
    #1;
    reset_n = 1;
    tick();
  endtask

  task automatic test_branch;
    goto_pc(5);
    Branch = 1; Zero = 1; Imediato = 16'hFFFD;
    tick();
    n_checks++;
    if (PC !== 10'd3) begin
      n_fail++;
      $display("FAIL beq_taken got %0d want 3", PC);
    end
    goto_pc(5);
    Branch = 1; Zero = 0; Imediato = 16'hFFFD;
    tick();
    n_checks++;
    if (PC !== 10'd6) begin
      n_fail++;
      $display("FAIL beq_not_taken got %0d want 6", PC);
    end
    goto_pc(5);
    BranchNE = 1; Zero = 0; Imediato = 16'd4;
    tick();
    n_checks++;
    if (PC !== 10'd10) begin
      n_fail++;
      $display("FAIL bne_taken got %0d want 10", PC);
    end
    clear_ctl();
  endtask

  task automatic test_jump;
    goto_pc(7);
    Jal = 1; EnderecoJump = 26'd40;
    #1;
    n_checks++;
    if (PCmais1 !== 10'd8) begin
      n_fail++;
      $display("FAIL jal_link got %0d want 8", PCmais1);
    end
    tick();
    n_checks++;
    if (PC !== 10'd40) begin
      n_fail++;
      $display("FAIL jal_target got %0d want 40", PC);
    end
    clear_ctl();
    Jr = 1; RegJr = 32'h0000_0123;
    tick();
    n_checks++;
    if (PC !== 10'h123) begin
      n_fail++;
      $display("FAIL jr_target got %0h want 123", PC);
    end
    clear_ctl();
    Jr = 1; RegJr = 32'hFFFF_F2AA; Jump = 1; EnderecoJump = 26'd50;
    tick();
    n_checks++;
    if (PC !== 10'h2AA) begin
      n_fail++;
      $display("FAIL jr_priority got %0h want 2aa", PC);
    end
    clear_ctl();
  endtask

  task automatic test_in;
    int pulses;
    int exp_pc;
    goto_pc(12);
    OpIn = 1;
    tick();
    clear_ctl();
    Jump = 1; EnderecoJump = 26'd99; Branch = 1; Zero = 1;
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if ({PC, AguardandoIn, LiberaIn} !== {10'd12, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL in_stall got pc=%0d wait=%b lib=%b want 12/1/0",
                 PC, AguardandoIn, LiberaIn);
      end
      tick();
    end
    clear_ctl();
    BotaoConfirma = 1;
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_pc = (i <= 2) ? 12 : 13 + (i - 3);
      pulses += int'(LiberaIn);
      n_checks++;
      if ({PC, LiberaIn, AguardandoIn} !==
          {10'(exp_pc), 1'(i == 2), 1'(i < 2)}) begin
        n_fail++;
        $display("FAIL in_release c%0d got pc=%0d lib=%b wait=%b want %0d/%b/%b",
                 i, PC, LiberaIn, AguardandoIn, exp_pc, i == 2, i < 2);
      end
      if (i == 5) BotaoConfirma = 0;
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL in_pulse_count got %0d want 1", pulses);
    end
  endtask

  task automatic test_in_held;
    int pulses;
    goto_pc(30);
    BotaoConfirma = 1;
    repeat (4) tick();
    OpIn = 1;
    tick();
    OpIn = 0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      pulses += int'(LiberaIn);
      n_checks++;
      if ({PC, AguardandoIn} !== {10'd34, 1'b1}) begin
        n_fail++;
        $display("FAIL held_stall got pc=%0d wait=%b want 34/1",
                 PC, AguardandoIn);
      end
      tick();
    end
    BotaoConfirma = 0;
    repeat (3) begin
      pulses += int'(LiberaIn);
      tick();
    end
    n_checks++;
    if (pulses !== 0 || PC !== 10'd34) begin
      n_fail++;
      $display("FAIL held_no_release got pulses=%0d pc=%0d want 0/34",
               pulses, PC);
    end
    BotaoConfirma = 1;
    tick();
    tick();
    n_checks++;
    if (LiberaIn !== 1'b1) begin
      n_fail++;
      $display("FAIL held_repress_pulse got %b want 1", LiberaIn);
    end
    tick();
    n_checks++;
    if ({PC, AguardandoIn} !== {10'd35, 1'b0}) begin
      n_fail++;
      $display("FAIL held_repress_pc got pc=%0d wait=%b want 35/0",
               PC, AguardandoIn);
    end
  endtask

  task automatic test_in_discard;
    int pulses;
    BotaoConfirma = 0;
    repeat (3) tick();
    BotaoConfirma = 1;
    tick();
    tick();
    OpIn = 1;
    #1;
    n_checks++;
    if ({PC, LiberaIn} !== {10'd40, 1'b0}) begin
      n_fail++;
      $display("FAIL discard_same_cycle got pc=%0d lib=%b want 40/0",
               PC, LiberaIn);
    end
    tick();
    OpIn = 0;
    BotaoConfirma = 0;
    pulses = 0;
    repeat (6) begin
      pulses += int'(LiberaIn);
      tick();
    end
    n_checks++;
    if (pulses !== 0 || PC !== 10'd40 || AguardandoIn !== 1'b1) begin
      n_fail++;
      $display("FAIL discard_stall got pulses=%0d pc=%0d wait=%b want 0/40/1",
               pulses, PC, AguardandoIn);
    end
    BotaoConfirma = 1;
    repeat (3) tick();
    BotaoConfirma = 0;
    n_checks++;
    if (PC !== 10'd41) begin
      n_fail++;
      $display("FAIL discard_exit got %0d want 41", PC);
    end
    repeat (3) tick();
  endtask

  task automatic test_halt;
    goto_pc(20);
    OpHalt = 1;
    tick();
    clear_ctl();
    Jump = 1; EnderecoJump = 26'd77;
    for (int i = 0; i < 50; i++) begin
      BotaoConfirma = 1'($urandom_range(0, 1));
      OpIn = 1'($urandom_range(0, 1));
      tick();
      n_checks++;
      if ({PC, Parado, LiberaIn} !== {10'd20, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL halt_freeze got pc=%0d halt=%b lib=%b want 20/1/0",
                 PC, Parado, LiberaIn);
      end
    end
    clear_ctl();
    BotaoConfirma = 0;
    #2;
    reset_n = 0;
    #1;
    n_checks++;
    if ({PC, Parado, AguardandoIn} !== {10'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL halt_reset got pc=%0d halt=%b want 0/0", PC, Parado);
    end
    #1;
    reset_n = 1;
    tick();
  endtask

  task automatic test_wrap;
    goto_pc(1023);
    #1;
    n_checks++;
    if (PCmais1 !== 10'd0) begin
      n_fail++;
      $display("FAIL wrap_pcmais1 got %0d want 0", PCmais1);
    end
    tick();
    n_checks++;
    if (PC !== 10'd0) begin
      n_fail++;
      $display("FAIL wrap_inc got %0d want 0", PC);
    end
    goto_pc(2);
    Branch = 1; Zero = 1; Imediato = 16'($signed(-10));
    tick();
    n_checks++;
    if (PC !== 10'd1017) begin
      n_fail++;
      $display("FAIL wrap_neg_branch got %0d want 1017", PC);
    end
    clear_ctl();
  endtask

  task automatic test_random;
    int exp_pc;
    exp_pc = int'($urandom_range(0, 1023));
    goto_pc(exp_pc);
    for (int i = 0; i < 200; i++) begin
      Jr       = ($urandom_range(0, 7) == 0);
      Jump     = ($urandom_range(0, 7) == 0);
      Jal      = ($urandom_range(0, 7) == 0);
      Branch   = ($urandom_range(0, 3) == 0);
      BranchNE = ($urandom_range(0, 3) == 0);
      Zero     = 1'($urandom_range(0, 1));
      EnderecoJump = 26'($urandom);
      Imediato     = 16'($urandom);
      RegJr        = $urandom;
      #1;
      n_checks++;
      if (PCmais1 !== 10'((exp_pc + 1) % 1024)) begin
        n_fail++;
        $display("FAIL rand_pcmais1 got %0d want %0d",
                 PCmais1, (exp_pc + 1) % 1024);
      end
      if (Jr)
        exp_pc = int'(RegJr % 1024);
      else if (Jump || Jal)
        exp_pc = int'(EnderecoJump % 1024);
      else if ((Branch && Zero) || (BranchNE && !Zero))
        exp_pc = (exp_pc + 1 + int'($signed(Imediato))) & 1023;
      else
        exp_pc = (exp_pc + 1) % 1024;
      tick();
      n_checks++;
      if (PC !== 10'(exp_pc)) begin
        n_fail++;
        $display("FAIL rand_next_pc step %0d got %0d want %0d",
                 i, PC, exp_pc);
      end
    end
    clear_ctl();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_in();
    test_in_held();
    test_in_discard();
    test_halt();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
